// File: rtl/uart_rx.sv
// uart_rx : oversampling 8N1 UART receiver.
//
// Deserialises frames arriving on rx into parallel words, sampling each bit
// in the middle of its period using the OSR-times oversampling strobe s_tick.
//
// Optional feature macro: UART_RX_PARITY_EN (adds a parity bit between the
// data bits and the stop bit, plus the parity_odd / parity_error ports).
//
// Ports:
//   clk            system clock, rising edge
//   reset_n        synchronous active-low reset
//   rx             asynchronous serial input, idle high
//   s_tick         one-clock oversampling strobe, OSR per bit period
//   parity_odd     (parity build only) 0 = even, 1 = odd parity
//   parity_error   (parity build only) registered, updated with rx_done_tick
//   rx_dout        last received data word
//   rx_done_tick   one-clock pulse when rx_dout is updated
//   framing_error  registered, reflects stop-bit sample of last frame
//   busy           high whenever a frame is being received
module uart_rx #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter int OSR     = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            rx,
   input  logic            s_tick,
`ifdef UART_RX_PARITY_EN
   input  logic            parity_odd,
   output logic            parity_error,
`endif
   output logic [DBIT-1:0] rx_dout,
   output logic            rx_done_tick,
   output logic            framing_error,
   output logic            busy
);

   localparam int SMAX = (OSR > SB_TICK) ? OSR : SB_TICK;
   localparam int SW   = $clog2(SMAX);
   localparam int NW   = $clog2(DBIT);

   localparam logic [SW-1:0] S_HALF = SW'(OSR / 2 - 1);
   localparam logic [SW-1:0] S_BIT  = SW'(OSR - 1);
   localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t            state_reg, state_next;
   logic [SW-1:0]     s_reg, s_next;
   logic [NW-1:0]     n_reg, n_next;
   logic [DBIT-1:0]   b_reg, b_next;
   logic [DBIT-1:0]   dout_reg, dout_next;
   logic              done_reg, done_next;
   logic              ferr_reg, ferr_next;
   logic [1:0]        sync_reg;
   logic              rx_s;
`ifdef UART_RX_PARITY_EN
   logic              par_reg, par_next;
   logic              perr_reg, perr_next;
`endif

   // Two-flop synchroniser; loaded with the idle level so reset never
   // looks like a start bit.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_reg <= 2'b11;
      end else begin
         sync_reg <= {sync_reg[0], rx};
      end
   end

   assign rx_s = sync_reg[1];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg <= IDLE;
         s_reg     <= '0;
         n_reg     <= '0;
         b_reg     <= '0;
         dout_reg  <= '0;
         done_reg  <= 1'b0;
         ferr_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_reg   <= 1'b0;
         perr_reg  <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;
         s_reg     <= s_next;
         n_reg     <= n_next;
         b_reg     <= b_next;
         dout_reg  <= dout_next;
         done_reg  <= done_next;
         ferr_reg  <= ferr_next;
`ifdef UART_RX_PARITY_EN
         par_reg   <= par_next;
         perr_reg  <= perr_next;
`endif
      end
   end

   always_comb begin
      state_next = state_reg;
      s_next     = s_reg;
      n_next     = n_reg;
      b_next     = b_reg;
      dout_next  = dout_reg;
      done_next  = 1'b0;
      ferr_next  = ferr_reg;
`ifdef UART_RX_PARITY_EN
      par_next   = par_reg;
      perr_next  = perr_reg;
`endif
      case (state_reg)
         IDLE: begin
            // Falling edge is acted on immediately, without waiting for a tick.
            if (!rx_s) begin
               state_next = START;
               s_next     = '0;
            end
         end
         START: begin
            if (s_tick) begin
               if (s_reg == S_HALF) begin
                  // Mid start bit: still low means a real start, else a glitch.
                  if (!rx_s) begin
                     state_next = DATA;
                     s_next     = '0;
                     n_next     = '0;
                  end else begin
                     state_next = IDLE;
                  end
               end else begin
                  s_next = s_reg + 1'b1;
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (s_reg == S_BIT) begin
                  s_next = '0;
                  b_next = {rx_s, b_reg[DBIT-1:1]};
                  if (n_reg == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_next = PARITY;
`else
                     state_next = STOP;
`endif
                  end else begin
                     n_next = n_reg + 1'b1;
                  end
               end else begin
                  s_next = s_reg + 1'b1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (s_tick) begin
               if (s_reg == S_BIT) begin
                  s_next     = '0;
                  par_next   = rx_s;
                  state_next = STOP;
               end else begin
                  s_next = s_reg + 1'b1;
               end
            end
         end
`endif
         STOP: begin
            if (s_tick) begin
               if (s_reg == S_STOP) begin
                  dout_next  = b_reg;
                  done_next  = 1'b1;
                  ferr_next  = ~rx_s;
`ifdef UART_RX_PARITY_EN
                  perr_next  = (^b_reg) ^ par_reg ^ parity_odd;
`endif
                  state_next = IDLE;
               end else begin
                  s_next = s_reg + 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign rx_dout       = dout_reg;
   assign rx_done_tick  = done_reg;
   assign framing_error = ferr_reg;
   assign busy          = (state_reg != IDLE);
`ifdef UART_RX_PARITY_EN
   assign parity_error  = perr_reg;
`endif

endmodule
